periph_timer_uart: RTL

PERIPH_TIMER_UART -- requirements
Module: periph_timer_uart

---
 rtl/periph_timer_uart_if.sv | 12 +
 rtl/periph_timer_uart.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/periph_timer_uart_if.sv
// Memory-stage bus into the timer/UART peripheral: strobes, address and data.
// rdata is driven combinationally by the peripheral.
interface periph_timer_uart_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/periph_timer_uart.sv
// Memory-mapped peripheral: auto-reloading 32-bit timer with interrupt,
// LED and seven-segment registers, and an 8N1 UART transmitter.
module periph_timer_uart #(
  parameter int BAUD_DIV = 10416
) (
  input  logic                       clk,
  input  logic                       reset,
  periph_timer_uart_if.slave         bus,
  output logic [7:0]                 led,
  output logic [11:0]                digi,
  output logic                       irqout,
  output logic                       UART_TX
);

  localparam logic [5:0] OFF_TH   = 6'h00;
  localparam logic [5:0] OFF_TL   = 6'h04;
  localparam logic [5:0] OFF_TCON = 6'h08;
  localparam logic [5:0] OFF_LED  = 6'h0C;
  localparam logic [5:0] OFF_DIGI = 6'h14;
  localparam logic [5:0] OFF_TXD  = 6'h18;
  localparam logic [5:0] OFF_UCON = 6'h20;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic [5:0]  off;
  logic        unused_addr_bits;
  logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi, wr_txd, rd_ucon;
  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic        reload;
  tx_state_t   state;
  logic [15:0] baud_cnt;
  logic        baud_end;
  logic [2:0]  bit_idx;
  logic [7:0]  txd;
  logic        done;
  logic        busy;

  assign off              = bus.addr[5:0];
  assign unused_addr_bits = &{1'b0, bus.addr[31:6]};

  assign wr_th   = bus.wr && (off == OFF_TH);
  assign wr_tl   = bus.wr && (off == OFF_TL);
  assign wr_tcon = bus.wr && (off == OFF_TCON);
  assign wr_led  = bus.wr && (off == OFF_LED);
  assign wr_digi = bus.wr && (off == OFF_DIGI);
  assign wr_txd  = bus.wr && (off == OFF_TXD);
  assign rd_ucon = bus.rd && (off == OFF_UCON);

  // A CPU write to TL suppresses both the count and the reload on that edge.
  assign reload   = tcon[0] && !wr_tl && (tl == 32'hFFFF_FFFF);
  assign irqout   = tcon[1] & tcon[2];
  assign baud_end = (baud_cnt == BAUD_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (wr_th)
        th <= bus.wdata;
      if (wr_tl)
        tl <= bus.wdata;
      else if (tcon[0])
        tl <= reload ? th : tl + 32'd1;
      if (wr_tcon)
        tcon <= bus.wdata[2:0];
      else if (reload && tcon[1])
        tcon[2] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led  <= '0;
      digi <= '0;
    end else begin
      if (wr_led)
        led <= bus.wdata[7:0];
      if (wr_digi)
        digi <= bus.wdata[11:0];
    end
  end

  // UART_TX is registered alongside the state so it changes exactly on state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      txd      <= '0;
      UART_TX  <= 1'b1;
      done     <= 1'b0;
    end else begin
      if (state == STOP && baud_end)
        done <= 1'b1;
      else if (rd_ucon)
        done <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_txd) begin
            txd      <= bus.wdata[7:0];
            state    <= START;
            baud_cnt <= '0;
            UART_TX  <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            UART_TX  <= txd[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              UART_TX <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              UART_TX <= txd[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_end) begin
            state    <= IDLE;
            baud_cnt <= '0;
            UART_TX  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      case (off)
        OFF_TH:   bus.rdata = th;
        OFF_TL:   bus.rdata = tl;
        OFF_TCON: bus.rdata = {29'd0, tcon};
        OFF_LED:  bus.rdata = {24'd0, led};
        OFF_DIGI: bus.rdata = {20'd0, digi};
        OFF_TXD:  bus.rdata = {24'd0, txd};
        OFF_UCON: bus.rdata = {28'd0, done, busy, 2'b00};
        default:  bus.rdata = '0;
      endcase
    end
  end

endmodule
